// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and oversample vote phases.
// Imported by the RX deframer and reusable by the TX path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  localparam logic [3:0] VOTE_PH0 = 4'd7;
  localparam logic [3:0] VOTE_PH1 = 4'd8;
  localparam logic [3:0] VOTE_PH2 = 4'd9;
  localparam logic [3:0] PH_LAST  = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-cycle tick every CLKS_PER_TICK clocks, restartable by clr.
// Latency: first tick CLKS_PER_TICK cycles after clr; no backpressure.
module uart_os_tick #(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_b || clr) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == TERM) && !clr;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: 16x oversampling with 3-sample majority vote into a one-deep valid/ready holding register.
// Byte valid ~9.6 bit periods after start edge; a byte arriving while the register is full is dropped (overrun).
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic       rx_meta, rxs, rxs_d;
  rx_state_t  state_q, state_d;
  logic [3:0] phase_q;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       s0_q, s1_q;
  logic       tick, start_edge, vote, at_vote, at_last;
  logic       deliver, ferr_d;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign start_edge = (state_q == IDLE) && rxs_d && !rxs;

  uart_os_tick #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_b || start_edge) begin
      phase_q <= 4'd0;
    end else if (tick) begin
      phase_q <= phase_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else if (tick) begin
      if (phase_q == VOTE_PH0) s0_q <= rxs;
      if (phase_q == VOTE_PH1) s1_q <= rxs;
    end
  end

  // Third vote sample is the live line value on the phase-9 tick.
  assign vote    = maj3(s0_q, s1_q, rxs);
  assign at_vote = tick && (phase_q == VOTE_PH2);
  assign at_last = tick && (phase_q == PH_LAST);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    deliver   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) state_d = START;
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
        end else if (at_last) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (at_vote) shreg_d = {vote, shreg_q[7:1]};
        if (at_last) begin
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      // Decide at mid-stop so the next start edge can be caught early.
      STOP: begin
        if (at_vote) begin
          if (vote) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at CLKS_PER_TICK = 4 (64 clk per bit).
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_uart_rx_deframer;

  localparam int CPT = 4;
  localparam int BIT = 16 * CPT;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  int valid_cyc = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int xfer_cnt  = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .CLKS_PER_TICK(CPT)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // noise_bit selects a data bit whose phase-8 sample is inverted; -1 for none.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int noise_bit);
    logic [9:0] frame;
    frame = {stop_lvl, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int s = 0; s < BIT; s++) begin
        rx_in = frame[j];
        if (noise_bit >= 0 && j == noise_bit + 1 && s >= 34 && s <= 37) rx_in = ~frame[j];
        cyc(1);
      end
    end
    rx_in = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_b) begin
      if (rx_valid)  valid_cyc++;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (rx_valid && rx_ready) begin
        xfer_cnt++;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int v0, f0, o0, x0;

    reset_b  = 1'b0;
    rx_in    = 1'b0;
    rx_ready = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst_rx_data",   32'(rx_data),   32'h00);
    chk("rst_rx_valid",  32'(rx_valid),  32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rx_in = 1'b1;
    cyc(3);
    reset_b = 1'b1;
    cyc(BIT);
    chk("idle_busy", 32'(busy), 32'd0);

    // Good byte with consumer ready.
    rx_ready = 1'b1;
    v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt; x0 = xfer_cnt;
    exp_q.push_back(8'h44);
    send_byte(8'h44, 1'b1, -1);
    cyc(2 * BIT);
    chk("good_xfers",     32'(xfer_cnt - x0),  32'd1);
    chk("good_valid_cyc", 32'(valid_cyc - v0), 32'd1);
    chk("good_ferr",      32'(ferr_cnt - f0),  32'd0);
    chk("good_ovr",       32'(ovr_cnt - o0),   32'd0);
    chk("good_valid_low", 32'(rx_valid),       32'd0);

    // Back-to-back under backpressure: second byte is dropped.
    rx_ready = 1'b0;
    o0 = ovr_cnt; x0 = xfer_cnt;
    exp_q.push_back(8'h31);
    send_byte(8'h31, 1'b1, -1);
    send_byte(8'h29, 1'b1, -1);
    cyc(BIT);
    chk("bp_ovr",      32'(ovr_cnt - o0), 32'd1);
    chk("bp_valid",    32'(rx_valid),     32'd1);
    chk("bp_hold",     32'(rx_data),      32'h31);
    chk("bp_no_xfer",  32'(xfer_cnt - x0), 32'd0);
    rx_ready = 1'b1;
    cyc(4);
    chk("bp_xfer",      32'(xfer_cnt - x0), 32'd1);
    chk("bp_valid_low", 32'(rx_valid),      32'd0);

    // Framing error followed by a long break.
    f0 = ferr_cnt; o0 = ovr_cnt; x0 = xfer_cnt;
    send_byte(8'hA5, 1'b0, -1);
    rx_in = 1'b0;
    cyc(20 * BIT);
    chk("brk_busy", 32'(busy), 32'd1);
    rx_in = 1'b1;
    cyc(2 * BIT);
    chk("fe_ferr",  32'(ferr_cnt - f0), 32'd1);
    chk("fe_xfer",  32'(xfer_cnt - x0), 32'd0);
    chk("fe_ovr",   32'(ovr_cnt - o0),  32'd0);
    chk("fe_valid", 32'(rx_valid),      32'd0);
    chk("fe_busy",  32'(busy),          32'd0);

    // Quarter-bit low glitch is rejected by the start vote.
    f0 = ferr_cnt; x0 = xfer_cnt;
    rx_in = 1'b0;
    cyc(16);
    rx_in = 1'b1;
    chk("gl_started", 32'(busy), 32'd1);
    cyc(40);
    chk("gl_idle", 32'(busy), 32'd0);
    cyc(2 * BIT);
    chk("gl_xfer", 32'(xfer_cnt - x0), 32'd0);
    chk("gl_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Single corrupted sample in data bit 3 is outvoted.
    x0 = xfer_cnt;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 3);
    cyc(2 * BIT);
    chk("nz_xfer", 32'(xfer_cnt - x0), 32'd1);

    // Reset mid-frame discards the partial byte.
    f0 = ferr_cnt; x0 = xfer_cnt;
    rx_in = 1'b0;
    cyc(BIT);
    rx_in = 1'b1;
    cyc(BIT);
    rx_in = 1'b0;
    cyc(2 * BIT);
    chk("ab_busy_pre", 32'(busy), 32'd1);
    rx_in   = 1'b1;
    reset_b = 1'b0;
    cyc(2);
    reset_b = 1'b1;
    cyc(1);
    chk("ab_busy_post", 32'(busy), 32'd0);
    cyc(BIT);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, -1);
    cyc(2 * BIT);
    chk("ab_xfer", 32'(xfer_cnt - x0), 32'd1);
    chk("ab_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
